fb_pixel_writer: RTL and testbench
==================================

# fb_pixel_writer

Receiving end of the pixel-write stream emitted by the drawing FSMs (hook, rope, miner, gold sprites). Accepts (x, y, color, write-enable) beats and buffers them in a 16-entry FIFO. Converts each beat to a linear 320x240 framebuffer address and writes it to the video-memory port under a ready handshake. Also provides a full-screen clear sequence that fills the framebuffer with a background color and signals completion.

## Interface
Parameters:
- `WIDTH`, 320, visible columns.
- `HEIGHT`, 240, visible rows.
- `FIFO_DEPTH`, 16, pixel buffer entries (power of two).
- `ADDR_W`, 17, framebuffer address width.

Ports:
- `clock`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_x`  in  9  pixel column.
- `in_y`  in  8  pixel row.
- `in_color`  in  12  RGB 4:4:4.
- `in_we`  in  1  pixel beat valid (drawer's writeEn).
- `in_ready`  out  1  FIFO not full.
- `clear_start`  in  1  one-cycle request to clear the screen.
- `bg_color`  in  12  fill color, sampled on clear_start.
- `clear_busy`  out  1  clear in progress.
- `clear_done`  out  1  one-cycle pulse when clear finishes.
- `mem_addr`  out  17  framebuffer address.
- `mem_data`  out  12  framebuffer write data.
- `mem_we`  out  1  write request.
- `mem_ready`  in  1  memory accepts write this cycle.
- `drop_count`  out  16  saturating count of out-of-range pixels.
- `overflow`  out  1  sticky: beat arrived while FIFO full.

## Operation
- States: S_RUN (drain FIFO), S_CLEAR (fill sweep), S_CLEAR_DONE (pulse, one cycle) -> S_RUN.
- Input: beat with in_we=1 and in_x<WIDTH and in_y<HEIGHT is enqueued if FIFO not full. Out-of-range beat is dropped and drop_count increments (saturates at 16'hFFFF). In-range beat while full is dropped and overflow sets. Out-of-range beats never set overflow.
- Address = in_y*320 + in_x, computed as (y<<8)+(y<<6)+x in 17 bits, before enqueue. FIFO stores {addr, color}, 29 bits.
- S_RUN: if FIFO not empty, present head on mem_addr/mem_data with mem_we=1. A transfer occurs when mem_we && mem_ready, and the head pops that cycle. Outputs hold stable while mem_ready=0.
- clear_start in S_RUN: latch bg_color and go to S_CLEAR. clear_start is ignored in other states. If a FIFO write is pending (mem_we=1, mem_ready=0), it completes first; the state changes on its transfer cycle.
- S_CLEAR: clear counter runs 0..76799. mem_we=1, mem_data=latched bg. The counter advances on each transfer. After address 76799 transfers, go to S_CLEAR_DONE. Input beats continue to be enqueued but are not drained until S_RUN, so drawing issued during a clear lands on top of the cleared screen.
- Simultaneous enqueue and pop when full: the pop frees space, but in_ready is computed from the registered count, so the beat is still rejected if count==FIFO_DEPTH at the cycle start.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_data=0, clear_busy=0, clear_done=0, drop_count=0, overflow=0. FIFO is emptied and state is S_RUN.
- Reset mid-clear aborts the sweep immediately. clear_done does not pulse.
- All outputs are registered. Latency is in_we to mem_we = 2 cycles with an empty FIFO and idle port: enqueue, then head register.
- Throughput is one pixel per cycle with mem_ready held high.
- clear_busy is high in S_CLEAR. clear_done is high exactly one cycle in S_CLEAR_DONE.
- A full clear takes 76800 cycles, plus stall cycles, plus 1 cycle.

## Structure
- Shared package `fb_pkg`: SCREEN_W=320, SCREEN_H=240, FB_ADDR_W=17, COLOR_W=12, state encodings, and a function for xy-to-address.
- Sub-module `pixel_fifo`: synchronous FIFO with parameterized width and depth, plus full/empty/count outputs.

## Test plan
- Single pixel (x=5, y=3, color=12'hBBD), mem_ready=1 -> mem_we pulses once, 2 cycles later, with mem_addr=965, mem_data=BBD.
- Burst of 20 beats with mem_ready=0 -> 16 enqueued; in_ready low after 16; overflow=1. Then raise mem_ready -> exactly 16 writes, in order.
- Beats at (320,0) and (0,240) -> no memory write; drop_count=2; overflow stays 0.
- clear_start with bg=12'h000 and mem_ready=1 -> 76800 writes covering addresses 0..76799. clear_busy is high throughout. clear_done pulses once, 76801 cycles after start.
- Pixel (319,239) issued mid-clear -> written (addr 76799) only after clear_done, so the final value is the pixel color.
- Reset asserted at clear counter 1000 -> mem_we=0 next cycle; clear_busy=0; no clear_done; FIFO empty.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, FSM state encodings and xy-to-address mapping
package fb_pkg;
    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 17;
    localparam int COLOR_W   = 12;

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_CLEAR      = 2'd1;
    localparam logic [1:0] S_CLEAR_DONE = 2'd2;

    // y*320 + x as shift-and-add so no multiplier is inferred
    function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [8:0] x, input logic [7:0] y);
        logic [FB_ADDR_W-1:0] yw;
        yw = FB_ADDR_W'(y);
        return (yw << 8) + (yw << 6) + FB_ADDR_W'(x);
    endfunction
endpackage

// File: rtl/fb_pixel_writer_fifo.sv
// pixel_fifo: synchronous FIFO
//   clock/reset : clock, sync active-high reset
//   push/din    : write side (caller never pushes when full)
//   pop         : read side (caller never pops when empty)
//   head/next   : entry at read pointer and the one behind it
//   full/empty/count : registered occupancy
module pixel_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [W-1:0]               next,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nx;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        rd_nx = rd_q + AW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        if (push) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign next  = mem_q[rd_nx];
    assign count = cnt_q;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers pixel beats and writes them, or a full-screen clear, to video memory
//   in_x/in_y/in_color/in_we, in_ready : pixel beat input
//   clear_start/bg_color, clear_busy/clear_done : screen clear control
//   mem_addr/mem_data/mem_we, mem_ready : framebuffer write port
//   drop_count/overflow : out-of-range and FIFO-full diagnostics
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [8:0]          in_x,
    input  logic [7:0]          in_y,
    input  logic [11:0]         in_color,
    input  logic                in_we,
    output logic                in_ready,
    input  logic                clear_start,
    input  logic [11:0]         bg_color,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [11:0]         mem_data,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [15:0]         drop_count,
    output logic                overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = ADDR_W + COLOR_W;
    localparam logic [8:0]        X_LIM = 9'(WIDTH);
    localparam logic [7:0]        Y_LIM = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WIDTH * HEIGHT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       data_q, data_d, bg_q, bg_d;
    logic              we_q, we_d, pend_q, pend_d, ovf_q, ovf_d;
    logic [15:0]       drop_q, drop_d;
    logic              in_range, push, pop, xfer, clear_req, more, full, empty;
    logic [DW-1:0]     head, next, sel;
    logic [CW-1:0]     count;

    assign in_range = in_x < X_LIM && in_y < Y_LIM;
    assign push     = in_we && in_range && !full;
    assign xfer     = we_q && mem_ready;
    assign pop      = state_q == S_RUN && xfer;
    assign sel      = pop ? next : head;
    // entries left after this cycle's pop; a same-cycle push only becomes visible next cycle
    assign more     = pop ? count != CW'(1) : !empty;

    pixel_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({ADDR_W'(xy_to_addr(in_x, in_y)), in_color}),
        .head  (head),
        .next  (next),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        pend_d    = pend_q;
        clear_req = state_q == S_RUN && (clear_start || pend_q);
        bg_d      = (state_q == S_RUN && clear_start) ? bg_color : bg_q;
        drop_d    = (in_we && !in_range && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        ovf_d     = ovf_q || (in_we && in_range && full);
        if (state_q == S_RUN) begin
            // a clear request waits for a stalled FIFO write to finish
            if (clear_req && (xfer || !we_q)) begin
                state_d = S_CLEAR;
                pend_d  = 1'b0;
                we_d    = 1'b1;
                addr_d  = '0;
                data_d  = bg_d;
            end else begin
                pend_d = clear_req;
                we_d   = more;
                addr_d = more ? sel[DW-1:COLOR_W] : addr_q;
                data_d = more ? sel[COLOR_W-1:0] : data_q;
            end
        end else if (state_q == S_CLEAR) begin
            // the presented address doubles as the sweep counter
            if (xfer && addr_q == LAST) begin
                state_d = S_CLEAR_DONE;
                we_d    = 1'b0;
            end else if (xfer) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end else begin
            state_d = S_RUN;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            pend_q  <= 1'b0;
            bg_q    <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            pend_q  <= pend_d;
            bg_q    <= bg_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready   = !full;
    assign clear_busy = state_q == S_CLEAR;
    assign clear_done = state_q == S_CLEAR_DONE;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign mem_we     = we_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [11:0] in_color = '0;
    logic        in_we = 1'b0;
    logic        in_ready;
    logic        clear_start = 1'b0;
    logic [11:0] bg_color = '0;
    logic        clear_busy, clear_done;
    logic [16:0] mem_addr;
    logic [11:0] mem_data;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [15:0] drop_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [28:0] wq[$];
    logic [11:0] fb[int];

    fb_pixel_writer dut (
        .clock(clock), .reset(reset), .in_x(in_x), .in_y(in_y), .in_color(in_color),
        .in_we(in_we), .in_ready(in_ready), .clear_start(clear_start), .bg_color(bg_color),
        .clear_busy(clear_busy), .clear_done(clear_done), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (!reset && mem_we && mem_ready) begin
            wq.push_back({mem_addr, mem_data});
            fb[int'(mem_addr)] = mem_data;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int k, bad, base;
        // reset values
        cyc(2);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        cyc(1);

        // single pixel: (5,3) -> 3*320+5 = 965
        mem_ready = 1'b1;
        in_x = 9'd5; in_y = 8'd3; in_color = 12'hBBD; in_we = 1'b1;
        cyc(1);
        in_we = 1'b0;
        chk("px_we_lat1", 32'(mem_we), 0);
        cyc(1);
        chk("px_we_lat2", 32'(mem_we), 1);
        chk("px_addr", 32'(mem_addr), 965);
        chk("px_data", 32'(mem_data), 32'hBBD);
        cyc(1);
        chk("px_we_after", 32'(mem_we), 0);
        chk("px_nwrites", wq.size(), 1);
        wq.delete();

        // burst of 20 beats into a stalled port: 16 fit
        mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_x = 9'(i); in_y = 8'd1; in_color = 12'(i + 12'h100); in_we = 1'b1;
            cyc(1);
        end
        in_we = 1'b0;
        chk("burst_in_ready", 32'(in_ready), 0);
        chk("burst_ovf", 32'(overflow), 1);
        chk("burst_stall_hold", 32'(mem_addr), 320);
        mem_ready = 1'b1;
        cyc(24);
        chk("burst_nwrites", wq.size(), 16);
        bad = 0;
        for (int i = 0; i < 16 && i < wq.size(); i++)
            if (wq[i] !== {17'(320 + i), 12'(i + 12'h100)}) bad++;
        chk("burst_order", bad, 0);
        chk("burst_ready_back", 32'(in_ready), 1);
        wq.delete();

        // out-of-range beats after a fresh reset
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        in_x = 9'd320; in_y = 8'd0; in_color = 12'hFFF; in_we = 1'b1;
        cyc(1);
        in_x = 9'd0; in_y = 8'd240;
        cyc(1);
        in_we = 1'b0;
        cyc(4);
        chk("oor_drop", 32'(drop_count), 2);
        chk("oor_ovf", 32'(overflow), 0);
        chk("oor_nwrites", wq.size(), 0);

        // full clear with a pixel issued mid-sweep
        bg_color = 12'h000; clear_start = 1'b1;
        k = 0; bad = 0;
        while (k < 80000) begin
            cyc(1);
            k++;
            if (k == 1) clear_start = 1'b0;
            if (k == 100) begin
                in_x = 9'd319; in_y = 8'd239; in_color = 12'hABC; in_we = 1'b1;
            end
            if (k == 101) in_we = 1'b0;
            if (clear_done) break;
            if (!clear_busy) bad++;
        end
        chk("clr_done_cycle", k, 76801);
        chk("clr_busy_thru", bad, 0);
        chk("clr_nwrites", wq.size(), 76800);
        bad = 0;
        for (int i = 0; i < 76800 && i < wq.size(); i++)
            if (wq[i] !== {17'(i), 12'h000}) bad++;
        chk("clr_sweep", bad, 0);
        cyc(1);
        chk("clr_done_once", 32'(clear_done), 0);
        chk("clr_busy_off", 32'(clear_busy), 0);
        cyc(3);
        chk("clr_px_nwrites", wq.size(), 76801);
        chk("clr_px_last", wq.size() > 0 ? 32'(wq[wq.size() - 1]) : 32'hDEAD, 32'({17'd76799, 12'hABC}));
        chk("clr_px_final", fb.exists(76799) ? 32'(fb[76799]) : 32'hDEAD, 32'hABC);

        // reset in the middle of a sweep, with a pixel parked in the FIFO
        clear_start = 1'b1;
        cyc(1);
        clear_start = 1'b0;
        in_x = 9'd1; in_y = 8'd1; in_color = 12'h123; in_we = 1'b1;
        cyc(1);
        in_we = 1'b0;
        k = 0;
        while (k < 2000 && mem_addr != 17'd1000) begin
            cyc(1);
            k++;
        end
        chk("mid_reached", 32'(mem_addr), 1000);
        reset = 1'b1;
        cyc(1);
        chk("mid_we", 32'(mem_we), 0);
        chk("mid_busy", 32'(clear_busy), 0);
        reset = 1'b0;
        base = wq.size();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (clear_done || mem_we) bad++;
        end
        chk("mid_quiet", bad, 0);
        chk("mid_fifo_empty", wq.size() - base, 0);
        chk("mid_in_ready", 32'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
